wb_bus_if: RTL and testbench

WB_BUS_IF -- requirements
Module: wb_bus_if

---
 rtl/wb_bus_if_if.sv | 27 ++
 rtl/wb_bus_if.sv | 118 +++++++++++
 tb/tb_wb_bus_if.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_if_if.sv
// Wishbone master-side bus bundle between the CPU bridge and a slave.
// Request fields are master outputs; ack and read data come back from the slave.
interface wb_bus_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      wishbone_cyc_o;
    logic                      wishbone_stb_o;
    logic                      wishbone_we_o;
    logic [ADDR_WIDTH-1:0]     wishbone_addr_o;
    logic [DATA_WIDTH-1:0]     wishbone_data_o;
    logic [DATA_WIDTH/8-1:0]   wishbone_sel_o;
    logic                      wishbone_ack_i;
    logic [DATA_WIDTH-1:0]     wishbone_data_i;

    modport master (
        output wishbone_cyc_o, wishbone_stb_o, wishbone_we_o,
        output wishbone_addr_o, wishbone_data_o, wishbone_sel_o,
        input  wishbone_ack_i, wishbone_data_i
    );

    modport slave (
        input  wishbone_cyc_o, wishbone_stb_o, wishbone_we_o,
        input  wishbone_addr_o, wishbone_data_o, wishbone_sel_o,
        output wishbone_ack_i, wishbone_data_i
    );
endinterface

// File: rtl/wb_bus_if.sv
// CPU-to-Wishbone bridge: one outstanding access, stall request while pending,
// read buffer held through pipeline stalls, flush aborts the access.
module wb_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall_i,
    input  logic                    flush_i,
    input  logic                    cpu_ce_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_data_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_sel_i,
    output logic [DATA_WIDTH-1:0]   cpu_data_o,
    output logic                    stallreq_o,
    wb_bus_if_if.master             wb
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_e;

    state_e                  state_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH/8-1:0] sel_q;
    logic [DATA_WIDTH-1:0]   rd_buf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            rd_buf_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        rd_buf_q <= '0;
                    end else if (cpu_ce_i) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= cpu_we_i;
                        addr_q  <= cpu_addr_i;
                        data_q  <= cpu_data_i;
                        sel_q   <= cpu_sel_i;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // flush wins over a same-cycle ack
                    if (flush_i || wb.wishbone_ack_i) begin
                        cyc_q  <= 1'b0;
                        stb_q  <= 1'b0;
                        we_q   <= 1'b0;
                        addr_q <= '0;
                        data_q <= '0;
                        sel_q  <= '0;
                    end
                    if (flush_i) begin
                        rd_buf_q <= '0;
                        state_q  <= IDLE;
                    end else if (wb.wishbone_ack_i) begin
                        if (!we_q) begin
                            rd_buf_q <= wb.wishbone_data_i;
                        end
                        state_q <= (stall_i != 6'd0) ? WAIT_STALL : IDLE;
                    end
                end
                WAIT_STALL: begin
                    if (flush_i) begin
                        rd_buf_q <= '0;
                        state_q  <= IDLE;
                    end else if (stall_i == 6'd0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        unique case (state_q)
            IDLE: begin
                stallreq_o = cpu_ce_i && !flush_i;
                cpu_data_o = rd_buf_q;
            end
            BUSY: begin
                stallreq_o = !wb.wishbone_ack_i && !flush_i;
                if (wb.wishbone_ack_i && !we_q) begin
                    cpu_data_o = wb.wishbone_data_i;
                end
            end
            WAIT_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
    end

    assign wb.wishbone_cyc_o  = cyc_q;
    assign wb.wishbone_stb_o  = stb_q;
    assign wb.wishbone_we_o   = we_q;
    assign wb.wishbone_addr_o = addr_q;
    assign wb.wishbone_data_o = data_q;
    assign wb.wishbone_sel_o  = sel_q;
endmodule

// File: tb/tb_wb_bus_if.sv
// Directed bench for wb_bus_if: per-cycle vector table plus
// hand-written reset and idle-ack sequences.
module tb_wb_bus_if;
    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;

    int n_chk;
    int n_fail;

    wb_bus_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sr;
        logic [31:0] rd;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sel;
    } obs_t;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        ack;
        logic [31:0] wbd;
        logic [5:0]  stall;
        logic        flush;
        obs_t        exp;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(
        input logic ce, input logic we, input logic [31:0] addr,
        input logic [31:0] data, input logic [3:0] sel,
        input logic ack, input logic [31:0] wbd,
        input logic [5:0] stall, input logic flush,
        input logic esr, input logic [31:0] erd, input logic ecyc,
        input logic ewe, input logic [31:0] eaddr,
        input logic [31:0] ewd, input logic [3:0] esel);
        vec_t v;
        v.ce = ce; v.we = we; v.addr = addr; v.data = data;
        v.sel = sel; v.ack = ack; v.wbd = wbd;
        v.stall = stall; v.flush = flush;
        v.exp = '{sr: esr, rd: erd, cyc: ecyc, stb: ecyc, we: ewe,
                  addr: eaddr, wd: ewd, sel: esel};
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.sr = stallreq_o; o.rd = cpu_data_o;
        o.cyc = bus.wishbone_cyc_o; o.stb = bus.wishbone_stb_o;
        o.we = bus.wishbone_we_o; o.addr = bus.wishbone_addr_o;
        o.wd = bus.wishbone_data_o; o.sel = bus.wishbone_sel_o;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sr=%0b rd=%h cyc=%0b stb=%0b we=%0b a=%h d=%h s=%h, want sr=%0b rd=%h cyc=%0b stb=%0b we=%0b a=%h d=%h s=%h",
                     name, act.sr, act.rd, act.cyc, act.stb, act.we,
                     act.addr, act.wd, act.sel, exp.sr, exp.rd, exp.cyc,
                     exp.stb, exp.we, exp.addr, exp.wd, exp.sel);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_ce_i = v.ce; cpu_we_i = v.we; cpu_addr_i = v.addr;
        cpu_data_i = v.data; cpu_sel_i = v.sel;
        bus.wishbone_ack_i = v.ack; bus.wishbone_data_i = v.wbd;
        stall_i = v.stall; flush_i = v.flush;
    endtask

    function automatic obs_t idle_obs(input logic sr, input logic [31:0] rd);
        return '{sr: sr, rd: rd, cyc: 1'b0, stb: 1'b0, we: 1'b0,
                 addr: 32'h0, wd: 32'h0, sel: 4'h0};
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        vt[0]  = mk(1,0,32'h100,0,4'hF, 0,0,0,0, 1,0,0,0,0,0,0);
        vt[1]  = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0,32'h100,0,4'hF);
        vt[2]  = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0,32'h100,0,4'hF);
        vt[3]  = mk(0,0,0,0,0, 1,32'hDEADBEEF,0,0,
                    0,32'hDEADBEEF,1,0,32'h100,0,4'hF);
        vt[4]  = mk(0,0,0,0,0, 0,0,0,0, 0,32'hDEADBEEF,0,0,0,0,0);
        vt[5]  = mk(1,1,32'h20,32'h12345678,4'hF, 0,0,0,0,
                    1,32'hDEADBEEF,0,0,0,0,0);
        vt[6]  = mk(0,0,0,0,0, 1,32'hCAFEF00D,0,0,
                    0,0,1,1,32'h20,32'h12345678,4'hF);
        vt[7]  = mk(0,0,0,0,0, 0,0,0,0, 0,32'hDEADBEEF,0,0,0,0,0);
        vt[8]  = mk(1,0,32'h44,0,4'hF, 0,0,0,0, 1,32'hDEADBEEF,0,0,0,0,0);
        vt[9]  = mk(0,0,0,0,0, 1,32'h0BADF00D,6'b000011,0,
                    0,32'h0BADF00D,1,0,32'h44,0,4'hF);
        vt[10] = mk(0,0,0,0,0, 0,0,6'b000011,0, 0,32'h0BADF00D,0,0,0,0,0);
        vt[11] = mk(0,0,0,0,0, 1,32'hFFFFFFFF,6'b000011,0,
                    0,32'h0BADF00D,0,0,0,0,0);
        vt[12] = mk(0,0,0,0,0, 0,0,0,0, 0,32'h0BADF00D,0,0,0,0,0);
        vt[13] = mk(1,0,32'h80,0,4'hF, 0,0,0,0, 1,32'h0BADF00D,0,0,0,0,0);
        vt[14] = mk(0,0,0,0,0, 0,0,0,1, 0,0,1,0,32'h80,0,4'hF);
        vt[15] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        vt[16] = mk(1,0,32'h90,0,4'hF, 0,0,0,0, 1,0,0,0,0,0,0);
        vt[17] = mk(0,0,0,0,0, 1,32'h11112222,0,1,
                    0,32'h11112222,1,0,32'h90,0,4'hF);
        vt[18] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        vt[19] = mk(1,0,32'hD0,0,4'hF, 0,0,0,1, 0,0,0,0,0,0,0);
        vt[20] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        vt[21] = mk(1,0,32'hA0,0,4'hF, 0,0,0,0, 1,0,0,0,0,0,0);
        vt[22] = mk(0,0,0,0,0, 1,32'h55AA55AA,6'b000001,0,
                    0,32'h55AA55AA,1,0,32'hA0,0,4'hF);
        vt[23] = mk(0,0,0,0,0, 0,0,6'b000001,1, 0,32'h55AA55AA,0,0,0,0,0);
        vt[24] = mk(1,1,32'hB0,0,4'h3, 0,0,6'b000001,0, 1,0,0,0,0,0,0);
        vt[25] = mk(0,0,0,0,0, 1,32'h99999999,0,0,
                    0,0,1,1,32'hB0,0,4'h3);
        vt[26] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);

        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        rst = 1'b1;
        @(negedge clk);
        check("reset_idle", idle_obs(1'b0, 32'h0));
        cpu_ce_i = 1'b1;
        #1;
        check("reset_ce_stallreq", idle_obs(1'b1, 32'h0));
        @(negedge clk);
        cpu_ce_i = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        // fill read buffer, then reset between edges mid-access
        @(posedge clk); #1;
        drive(mk(1,0,32'hC0,0,4'hF, 0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0, 1,32'h00000077,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
        @(negedge clk);
        check("buf_before_rst", idle_obs(1'b0, 32'h77));
        @(posedge clk); #1;
        drive(mk(1,0,32'hE0,0,4'hF, 0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk); #1;
        cpu_ce_i = 1'b0;
        @(negedge clk);
        check("busy_before_rst",
              '{sr: 1'b1, rd: 32'h0, cyc: 1'b1, stb: 1'b1, we: 1'b0,
                addr: 32'hE0, wd: 32'h0, sel: 4'hF});
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_drop", idle_obs(1'b0, 32'h0));
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.wishbone_ack_i = 1'b1;
        bus.wishbone_data_i = 32'hA5A5A5A5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("spurious_ack%0d", k), idle_obs(1'b0, 32'h0));
        end
        bus.wishbone_ack_i = 1'b0;
        @(negedge clk);
        check("post_rst_idle", idle_obs(1'b0, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
